// File: rtl/image_xform_engine_pkg.sv
// Shared definitions for the image transform engine: FSM state encoding and
// the bit positions of the mode word.
package image_xform_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int unsigned MODE_INV   = 32'd0;
    localparam int unsigned MODE_HFLIP = 32'd1;
    localparam int unsigned MODE_VFLIP = 32'd2;

endpackage

// File: rtl/image_xform_engine_if.sv
// Source-read / destination-write pixel bus between the transform engine
// (master) and the frame memories (slave).
interface image_xform_engine_if #(
    parameter int XW     = 9,
    parameter int YW     = 8,
    parameter int DATA_W = 32
) ();
    logic              rd_en;
    logic [XW-1:0]     rd_x;
    logic [YW-1:0]     rd_y;
    logic [DATA_W-1:0] rd_data;
    logic              wr_en;
    logic [XW-1:0]     wr_x;
    logic [YW-1:0]     wr_y;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output rd_en, rd_x, rd_y,
        input  rd_data,
        output wr_en, wr_x, wr_y, wr_data
    );

    modport slave (
        input  rd_en, rd_x, rd_y,
        output rd_data,
        input  wr_en, wr_x, wr_y, wr_data
    );
endinterface

// File: rtl/image_xform_engine_xy_raster_cnt.sv
// Raster-order x/y pixel counter: x runs fastest, y steps when x wraps, and
// last flags the final pixel of the frame.
module xy_raster_cnt #(
    parameter int IMG_W = 320,
    parameter int IMG_H = 240
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     adv,
    output logic [$clog2(IMG_W)-1:0] x,
    output logic [$clog2(IMG_H)-1:0] y,
    output logic                     last
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    logic x_end_s;
    logic y_end_s;

    // End-of-row / end-of-frame decode from the current position.
    always_comb begin
        x_end_s = (x == XW'(IMG_W - 1));
        y_end_s = (y == YW'(IMG_H - 1));
        last    = x_end_s && y_end_s;
    end

    // Position registers: clear on pass start, step once per advance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x <= '0;
            y <= '0;
        end else if (clr) begin
            x <= '0;
            y <= '0;
        end else if (adv) begin
            if (x_end_s) begin
                x <= '0;
                if (y_end_s) begin
                    y <= '0;
                end else begin
                    y <= y + YW'(1'b1);
                end
            end else begin
                x <= x + XW'(1'b1);
            end
        end
    end

endmodule

// File: rtl/image_xform_engine.sv
// Frame-pass pixel transform: reads each source pixel in raster order, applies
// optional inversion and horizontal/vertical mirroring, and writes it back out.
module image_xform_engine
    import image_xform_pkg::*;
#(
    parameter int IMG_W  = 320,
    parameter int IMG_H  = 240,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [2:0]          mode,
    output logic                busy,
    output logic                done,
    image_xform_engine_if.master bus
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    state_t            state_r;
    logic [2:0]        mode_r;
    logic              last_r;

    logic [XW-1:0]     x_s;
    logic [YW-1:0]     y_s;
    logic              last_s;
    logic              clr_s;
    logic              adv_s;
    logic [DATA_W-1:0] pix_s;
    logic [XW-1:0]     dst_x_s;
    logic [YW-1:0]     dst_y_s;

    xy_raster_cnt #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_raster (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr_s),
        .adv  (adv_s),
        .x    (x_s),
        .y    (y_s),
        .last (last_s)
    );

    // Counter control: the raster steps as the pixel moves into WRITE, so the
    // following READ can issue the next address straight from the counter.
    always_comb begin
        clr_s = 1'b0;
        adv_s = 1'b0;
        case (state_r)
            IDLE:    clr_s = start;
            WAIT:    adv_s = !abort;
            default: begin
                clr_s = 1'b0;
                adv_s = 1'b0;
            end
        endcase
    end

    // Pixel transform and mirrored destination address for the current pixel.
    always_comb begin
        if (mode_r[MODE_INV]) begin
            pix_s = ~bus.rd_data;
        end else begin
            pix_s = bus.rd_data;
        end
        if (mode_r[MODE_HFLIP]) begin
            dst_x_s = XW'(IMG_W - 1) - x_s;
        end else begin
            dst_x_s = x_s;
        end
        if (mode_r[MODE_VFLIP]) begin
            dst_y_s = YW'(IMG_H - 1) - y_s;
        end else begin
            dst_y_s = y_s;
        end
    end

    // Pass sequencer; strobes and buses are registered alongside the state
    // they belong to and return to zero whenever not explicitly driven.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            mode_r      <= 3'b000;
            last_r      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            bus.rd_en   <= 1'b0;
            bus.rd_x    <= '0;
            bus.rd_y    <= '0;
            bus.wr_en   <= 1'b0;
            bus.wr_x    <= '0;
            bus.wr_y    <= '0;
            bus.wr_data <= '0;
        end else begin
            done        <= 1'b0;
            bus.rd_en   <= 1'b0;
            bus.rd_x    <= '0;
            bus.rd_y    <= '0;
            bus.wr_en   <= 1'b0;
            bus.wr_x    <= '0;
            bus.wr_y    <= '0;
            bus.wr_data <= '0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        mode_r    <= mode;
                        last_r    <= 1'b0;
                        busy      <= 1'b1;
                        bus.rd_en <= 1'b1;
                        state_r   <= READ;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                READ: begin
                    if (abort) begin
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                WAIT: begin
                    if (abort) begin
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        // wr_data doubles as the processed-pixel register
                        bus.wr_en   <= 1'b1;
                        bus.wr_x    <= dst_x_s;
                        bus.wr_y    <= dst_y_s;
                        bus.wr_data <= pix_s;
                        last_r      <= last_s;
                        state_r     <= WRITE;
                    end
                end
                WRITE: begin
                    if (abort) begin
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end else if (last_r) begin
                        done    <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        bus.rd_en <= 1'b1;
                        bus.rd_x  <= x_s;
                        bus.rd_y  <= y_s;
                        state_r   <= READ;
                    end
                end
                DONE: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_image_xform_engine.sv
// Scoreboard bench for image_xform_engine on a 4x3 frame of 8-bit pixels whose
// source word is 16*y + x.
module tb_image_xform_engine;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int DW = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [2:0] mode;
    logic       busy;
    logic       done;

    image_xform_engine_if #(.XW(2), .YW(2), .DATA_W(DW)) xif ();

    image_xform_engine #(
        .IMG_W  (W),
        .IMG_H  (H),
        .DATA_W (DW)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .abort (abort),
        .mode  (mode),
        .busy  (busy),
        .done  (done),
        .bus   (xif)
    );

    always #5 clk = ~clk;

    int checks     = 0;
    int failures   = 0;
    int cyc        = 0;
    int done_count = 0;
    int done_cyc   = 0;
    int rd_cnt     = 0;
    int wr_cnt     = 0;
    logic [11:0] sb[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Source memory: one-cycle read latency.
    always @(posedge clk) begin
        if (xif.rd_en) begin
            xif.rd_data <= 8'(int'(xif.rd_y) * 16 + int'(xif.rd_x));
        end else begin
            xif.rd_data <= 8'h00;
        end
    end

    always @(posedge clk) cyc++;

    // Output monitor: scoreboard writes, count strobes, check bus hygiene.
    always @(negedge clk) begin
        logic [11:0] e;
        chk("rd_wr_excl", {31'd0, xif.rd_en & xif.wr_en}, 32'd0);
        if (xif.rd_en) begin
            rd_cnt++;
        end else begin
            chk("rd_idle_zero", {28'd0, xif.rd_x, xif.rd_y}, 32'd0);
        end
        if (xif.wr_en) begin
            wr_cnt++;
            if (sb.size() == 0) begin
                chk("wr_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("wr_pix", {20'd0, xif.wr_x, xif.wr_y, xif.wr_data}, {20'd0, e});
            end
        end else begin
            chk("wr_idle_zero", {20'd0, xif.wr_x, xif.wr_y, xif.wr_data}, 32'd0);
        end
        if (done) begin
            done_count++;
            done_cyc = cyc;
        end
    end

    task automatic push_exp(input logic [2:0] m, input int npix);
        int x, y, wx, wy;
        logic [7:0] d;
        for (int p = 0; p < npix; p++) begin
            x  = p % W;
            y  = p / W;
            d  = 8'(16 * y + x);
            if (m[0]) d = ~d;
            wx = m[1] ? (W - 1 - x) : x;
            wy = m[2] ? (H - 1 - y) : y;
            sb.push_back({2'(wx), 2'(wy), d});
        end
    endtask

    // One pass; optional stray start at start_rel, abort at abort_rel
    // (abort_rel == 0 means abort together with start).
    task automatic run_pass(input logic [2:0] m, input int start_rel, input int abort_rel, input int npix);
        int d0, r0, w0, sc;
        push_exp(m, npix);
        d0 = done_count;
        r0 = rd_cnt;
        w0 = wr_cnt;
        mode  = m;
        start = 1'b1;
        abort = (abort_rel == 0);
        sc = cyc;
        step();
        start = 1'b0;
        abort = 1'b0;
        for (int rel = 1; rel < 200; rel++) begin
            if (done_count != d0) break;
            if (abort_rel > 0 && rel > abort_rel + 3) break;
            if (rel == start_rel) begin
                start = 1'b1;
                mode  = 3'b001;
            end
            if (rel == abort_rel) abort = 1'b1;
            if (abort_rel > 0 && rel == abort_rel + 1)
                chk("abort_idle", {29'd0, busy, xif.rd_en, xif.wr_en}, 32'd0);
            step();
            start = 1'b0;
            abort = 1'b0;
        end
        if (abort_rel > 0) begin
            chk("abort_no_done", done_count - d0, 32'd0);
            chk("abort_wr_cnt", wr_cnt - w0, npix);
            chk("abort_busy", {31'd0, busy}, 32'd0);
        end else begin
            chk("done_seen", done_count - d0, 32'd1);
            chk("done_lat", done_cyc - sc, 32'd37);
            chk("busy_after_done", {31'd0, busy}, 32'd0);
        end
        repeat (10) step();
        chk("rd_cnt", rd_cnt - r0, (abort_rel > 0) ? npix + 1 : npix);
        chk("done_total", done_count - d0, (abort_rel > 0) ? 32'd0 : 32'd1);
        chk("sb_empty", sb.size(), 32'd0);
        sb.delete();
    endtask

    task automatic reset_mid_pass();
        int d0, r0, w0;
        push_exp(3'b000, 2);
        d0 = done_count;
        r0 = rd_cnt;
        w0 = wr_cnt;
        mode  = 3'b000;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (8) step();
        chk("pre_rst_write", {31'd0, xif.wr_en}, 32'd1);
        rst = 1'b0;
        #1;
        chk("rst_outputs", {9'd0, busy, done, xif.rd_en, xif.rd_x, xif.rd_y, xif.wr_en,
                            xif.wr_x, xif.wr_y, xif.wr_data}, 32'd0);
        repeat (3) step();
        rst = 1'b1;
        repeat (12) step();
        chk("rst_rd_cnt", rd_cnt - r0, 32'd3);
        chk("rst_wr_cnt", wr_cnt - w0, 32'd2);
        chk("rst_no_done", done_count - d0, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_sb_empty", sb.size(), 32'd0);
        sb.delete();
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        mode  = 3'b000;
        repeat (2) step();
        chk("reset_state", {9'd0, busy, done, xif.rd_en, xif.rd_x, xif.rd_y, xif.wr_en,
                            xif.wr_x, xif.wr_y, xif.wr_data}, 32'd0);
        rst = 1'b1;
        repeat (2) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("idle_abort", {31'd0, busy}, 32'd0);

        run_pass(3'b000, -1, -1, 12);
        run_pass(3'b001, -1, -1, 12);
        run_pass(3'b110, -1, -1, 12);
        run_pass(3'b000, 16, -1, 12);
        run_pass(3'b000, -1, 20, 6);
        run_pass(3'b011, -1, 0, 12);
        reset_mid_pass();
        run_pass(3'b101, -1, -1, 12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=%0d exp=finish", cyc);
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/image_xform_engine.md
IMAGE_XFORM_ENGINE -- requirements
Module: image_xform_engine

Interface
REQ-001 SHALL have parameter IMG_W, default 320, pixels per row.
REQ-002 SHALL have parameter IMG_H, default 240, rows per frame.
REQ-003 SHALL have parameter DATA_W, default 32, pixel word width.
REQ-004 SHALL derive XW=$clog2(IMG_W) and YW=$clog2(IMG_H) locally; these are not user-overridable.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  begin a frame pass; sampled only in IDLE.
REQ-008 abort  input  1  terminate the pass in progress.
REQ-009 mode  input  3  bit0 invert, bit1 hflip, bit2 vflip; latched on accepted start.
REQ-010 busy  output  1  high from accepted start until DONE or abort.
REQ-011 done  output  1  one-cycle pulse at normal pass completion.
REQ-012 rd_en, rd_x[XW], rd_y[YW]  output  source read strobe and address.
REQ-013 rd_data  input  DATA_W  source word, valid exactly one cycle after rd_en.
REQ-014 wr_en, wr_x[XW], wr_y[YW], wr_data[DATA_W]  output  destination write strobe, address and data.

Function
REQ-015 SHALL implement FSM states IDLE, READ, WAIT, WRITE, DONE.
REQ-016 IDLE: start=1 SHALL latch mode, clear x=y=0 and go to READ; otherwise SHALL stay in IDLE.
REQ-017 READ: SHALL assert rd_en=1 with rd_x=x and rd_y=y for one cycle, then go to WAIT.
REQ-018 WAIT: SHALL register rd_data, XORed with all-ones when mode_q[0]=1, into pix_q, then go to WRITE.
REQ-019 WRITE: SHALL assert wr_en=1 for one cycle with wr_data=pix_q.
REQ-020 WRITE address: wr_x = mode_q[1] ? IMG_W-1-x : x; wr_y = mode_q[2] ? IMG_H-1-y : y.
REQ-021 After WRITE, raster advance: x increments; at x=IMG_W-1, x wraps to 0 and y increments.
REQ-022 After WRITE at x=IMG_W-1, y=IMG_H-1, SHALL go to DONE; otherwise SHALL go to READ.
REQ-023 DONE: SHALL pulse done=1 for one cycle, drop busy, and return to IDLE.
REQ-024 Throughput SHALL be exactly 3 cycles per pixel: first rd_en one cycle after the start cycle; done 3*IMG_W*IMG_H+1 cycles after the start cycle.
REQ-025 start while busy SHALL be ignored; mode changes mid-pass SHALL have no effect.
REQ-026 abort=1 in READ/WAIT/WRITE SHALL force IDLE next cycle, with no done and no further rd_en/wr_en.
REQ-027 abort in IDLE or DONE SHALL be ignored; in DONE, the done pulse still occurs.
REQ-028 abort and start in the same IDLE cycle: start SHALL win.
REQ-029 rd_en and wr_en SHALL never be high in the same cycle; addresses and data SHALL be 0 when their strobe is low.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 rst low SHALL immediately force state=IDLE, x=y=0, mode_q=0, pix_q=0, busy=0, done=0, rd_en=0, wr_en=0, and all address/data outputs to 0.
REQ-032 Reset mid-pass SHALL abandon the pass silently; after release, no done and no strobes until a new start.

Structure
REQ-033 Shared package image_xform_pkg SHALL hold the state enum and mode bit-index constants (MODE_INV=0, MODE_HFLIP=1, MODE_VFLIP=2).
REQ-034 Raster x/y counting SHALL be one sub-module, xy_raster_cnt (params IMG_W/IMG_H; ports clr, adv, x, y, last).

Verification (IMG_W=4, IMG_H=3, DATA_W=8; source word = 16*y + x)
REQ-035 mode=000, start -> 12 writes with wr(x,y)=data 16y+x; done at cycle 37 after start; busy low the cycle after done.
REQ-036 mode=001 -> wr(1,0)=0xFE; wr(3,2)=0xDC.
REQ-037 mode=110 -> source (0,0) written at (3,2) with 0x00; source (3,2) written at (0,0) with 0x23.
REQ-038 start pulsed with mode=001 at pixel 5 of a mode=000 pass -> pass unchanged, single done, no second pass.
REQ-039 abort asserted in WAIT of pixel 6 -> no wr_en for pixel 6, no done, IDLE next cycle; a new start then completes normally.
REQ-040 rst low in WRITE of pixel 2 -> all outputs 0 immediately; after release, no strobes until start.
